raster_scanout: RTL and testbench
=================================

Name: raster_scanout

Overview:
- Raster transmitter: reads a DEPTH-bit pixel framebuffer through a synchronous RAM read port and emits the pixel-enable/blank/sync video stream that the rotation and mixer blocks consume.
- Replaces a core's native video generator when a core renders into a double-buffered frame RAM.
- The output stream drives the `ce`/`video_in`/`hblank`/`vblank` inputs of the screen rotator, or the video mixer directly.

Parameters:
- WIDTH, 288, active pixels per line.
- HEIGHT, 224, active lines per frame.
- HFP, 8, horizontal front porch in pixels.
- HSW, 32, hsync width in pixels.
- HBP, 56, horizontal back porch in pixels.
- VFP, 16, vertical front porch in lines.
- VSW, 8, vsync width in lines.
- VBP, 16, vertical back porch in lines.
- DEPTH, 8, pixel width.
- CE_DIV, 4, clk cycles per pixel; must be >= 2.
- AW, 17, read address width.
- BANK_OFS, 65536, address offset of bank 1.

Ports:
- clk  in  1  video clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- bank  in  1  framebuffer bank select; sampled at frame start.
- rd_addr  out  AW  RAM read address; RAM returns data 1 clk later.
- rd_data  in  DEPTH  RAM read data.
- ce_pix  out  1  one-clk pixel strobe.
- video_out  out  DEPTH  pixel value.
- hblank  out  1  horizontal blank.
- vblank  out  1  vertical blank.
- hsync  out  1  horizontal sync, active high.
- vsync  out  1  vertical sync, active high.
- frame_start  out  1  one-clk pulse, coincident with ce_pix of pixel (0,0).

Behaviour:
- Reset values:
  - rd_addr=0, video_out=0, ce_pix=0, hsync=0, vsync=0, frame_start=0.
  - hblank=1, vblank=1.
  - Internal: h=0, v=0, divider=0, running=0.
- Divider:
  - Counts 0..CE_DIV-1 continuously while reset_n is high.
  - An internal tick T occurs when divider==CE_DIV-1.
- Counters:
  - HTOT=WIDTH+HFP+HSW+HBP; VTOT=HEIGHT+VFP+VSW+VBP.
  - On T with running=1, h increments. At h==HTOT-1, h wraps to 0 and v increments. At v==VTOT-1 with h wrap, v wraps to 0.
- Run state, two states IDLE and RUN:
  - IDLE→RUN on T when enable=1. Counters start at (0,0).
  - RUN→IDLE only on the T where (h,v) would wrap to (0,0) and enable=0. The current frame always completes.
  - In IDLE, no ce_pix pulses are emitted, outputs hold their blank state, and h=v=0.
- Address:
  - At frame start, base is set to bank?BANK_OFS:0 and the offset to 0.
  - rd_addr=base+offset is presented on T for every active pixel (h<WIDTH, v<HEIGHT).
  - The offset increments once per active pixel and is linear row-major: v*WIDTH+h.
  - The offset wraps modulo 2^AW. Sum truncation to AW is intentional.
  - A bank change mid-frame takes effect only at the next frame start.
- Pipeline:
  - Timing signals are computed at T and delayed exactly 2 clk. ce_pix pulses at T+2.
  - video_out, hblank, vblank, hsync, vsync and frame_start all update on that same T+2 clock, so downstream samples them with ce_pix.
  - video_out = rd_data captured at T+1 for active pixels, and 0 during any blank.
- Timing signal decode:
  - hblank=1 for h>=WIDTH.
  - vblank=1 for v>=HEIGHT.
  - hsync=1 for WIDTH+HFP <= h < WIDTH+HFP+HSW.
  - vsync updates only on the tick where h==WIDTH+HFP, becoming 1 for HEIGHT+VFP <= v < HEIGHT+VFP+VSW. It therefore changes aligned to the hsync leading edge.
- Reset asserted mid-frame:
  - All outputs return immediately (asynchronously) to their reset values.
  - After release, operation restarts from IDLE; no partial frame is resumed.
- enable toggling within a frame has no visible effect until the frame end.

Test Plan:
- Frame period:
  - Stimulus: defaults, enable=1 from reset.
  - Required: ce_pix period 4 clk; HTOT=384 ce_pix per line; hblank high for 96 ce_pix; hsync high for 32 ce_pix starting 8 ce_pix after hblank rises; 264 lines per frame; vsync high for exactly 8 lines; frame_start period 384*264*4=405504 clk.
- Address and latency:
  - Stimulus: RAM model returning rd_data=rd_addr[7:0].
  - Required: line 0 pixels 0..287 give video_out 0x00..0x1F, wrapping; line 1 pixel 0 gives 288&0xFF=0x20; video_out=0 whenever hblank|vblank.
- Bank:
  - Stimulus: bank=1 held through frame_start, then toggled to 0 mid-frame.
  - Required: first rd_addr of that frame is 65536; the frame's last active address is 65536+64511; next frame starts at 0.
- Enable drop:
  - Stimulus: deassert enable at line 100.
  - Required: ce_pix continues until line 263 completes, then no further ce_pix; hblank=vblank=1 held; re-enable restarts with frame_start on the first ce_pix.
- Async reset mid-active:
  - Stimulus: pull reset_n low between clock edges.
  - Required: outputs go to reset values before the next edge; after release plus enable, the first ce_pix is pixel (0,0) with frame_start=1.
- CE_DIV=2 parameterisation:
  - Required: ce_pix every 2 clk; data still aligned, since each address is issued 2 clk before its pixel strobe.

Source files
------------

// File: rtl/raster_scanout.sv
// Raster scan-out: reads a pixel framebuffer through a synchronous RAM port
// and emits the pixel strobe / blank / sync stream for the rotator or mixer.
module raster_scanout #(
  parameter int WIDTH    = 288,
  parameter int HEIGHT   = 224,
  parameter int HFP      = 8,
  parameter int HSW      = 32,
  parameter int HBP      = 56,
  parameter int VFP      = 16,
  parameter int VSW      = 8,
  parameter int VBP      = 16,
  parameter int DEPTH    = 8,
  parameter int CE_DIV   = 4,
  parameter int AW       = 17,
  parameter int BANK_OFS = 65536
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             bank,
  output logic [AW-1:0]    rd_addr,
  input  logic [DEPTH-1:0] rd_data,
  output logic             ce_pix,
  output logic [DEPTH-1:0] video_out,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int HTOT = WIDTH + HFP + HSW + HBP;
  localparam int VTOT = HEIGHT + VFP + VSW + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int DW   = $clog2(CE_DIV);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic [AW-1:0]   base, offset, bank_base;
  logic            tick, step, h_last, v_last, first_px;
  logic            act, hb_c, vb_c, hs_c, vs_c;
  logic [31:0]     hx, vx;
  logic            s_act, s_hb, s_vb, s_hs, s_vs, s_first;
  logic            e1, e2;

  assign tick      = (div == DW'(CE_DIV - 1));
  assign step      = tick && (state == RUN);
  assign h_last    = (h == HW'(HTOT - 1));
  assign v_last    = (v == VW'(VTOT - 1));
  assign hx        = 32'(h);
  assign vx        = 32'(v);
  assign first_px  = (h == '0) && (v == '0);
  assign hb_c      = hx >= 32'(WIDTH);
  assign vb_c      = vx >= 32'(HEIGHT);
  assign act       = !hb_c && !vb_c;
  assign hs_c      = (hx >= 32'(WIDTH + HFP)) && (hx < 32'(WIDTH + HFP + HSW));
  assign vs_c      = (vx >= 32'(HEIGHT + VFP)) && (vx < 32'(HEIGHT + VFP + VSW));
  assign bank_base = bank ? AW'(BANK_OFS) : '0;

  // Free-running pixel clock divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

  // Run state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Start on a tick when enabled; stop only once the frame wraps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tick && enable) state_nx = RUN;
      RUN:  if (tick && h_last && v_last && !enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Raster position; wraps to (0,0), which is also where IDLE parks it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (step) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  // Read address: bank latched on pixel (0,0), linear offset modulo 2^AW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      base    <= '0;
      offset  <= '0;
    end else if (step && act) begin
      if (first_px) begin
        base    <= bank_base;
        rd_addr <= bank_base;
        offset  <= AW'(1);
      end else begin
        rd_addr <= base + offset;
        offset  <= offset + AW'(1);
      end
    end
  end

  // Timing decode captured on the tick; vsync only moves at the hsync edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_act   <= 1'b0;
      s_hb    <= 1'b1;
      s_vb    <= 1'b1;
      s_hs    <= 1'b0;
      s_vs    <= 1'b0;
      s_first <= 1'b0;
    end else if (step) begin
      s_act   <= act;
      s_hb    <= hb_c;
      s_vb    <= vb_c;
      s_hs    <= hs_c;
      s_first <= first_px;
      if (hx == 32'(WIDTH + HFP)) s_vs <= vs_c;
    end
  end

  // Two-clock delay of the tick to line up with RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e1 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      e1 <= step;
      e2 <= e1;
    end
  end

  // Output stage: everything updates together with the pixel strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_pix      <= 1'b0;
      frame_start <= 1'b0;
      video_out   <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
    end else begin
      ce_pix      <= e2;
      frame_start <= e2 && s_first;
      if (e2) begin
        video_out <= s_act ? rd_data : '0;
        hblank    <= s_hb;
        vblank    <= s_vb;
        hsync     <= s_hs;
        vsync     <= s_vs;
      end
    end
  end

endmodule

// File: tb/tb_raster_scanout.sv
// Directed bench for raster_scanout: a small raster on two instances
// (divide-by-4 and divide-by-2), with per-pixel expectations queued when
// each frame is scheduled and checked as strobes come out.
module tb_raster_scanout;

  localparam int W = 8, H = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VFP = 1, VSW = 1, VBP = 1;
  localparam int HTOT = W + HFP + HSW + HBP;
  localparam int VTOT = H + VFP + VSW + VBP;
  localparam int CE_A = 4, CE_B = 2;
  localparam int OFS = 240;

  typedef struct {
    logic [7:0] vid;
    logic       hb, vb, hs, vs, fs;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, enable_a, bank_a, enable_b;
  logic [7:0] addr_a, addr_b, ram_a, ram_b, vid_a, vid_b;
  logic       ce_a, hb_a, vb_a, hs_a, vs_a, fs_a;
  logic       ce_b, hb_b, vb_b, hs_b, vs_b, fs_b;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0, bad = 0;
  int   gap_a = 0, gap_b = 0;

  always #5 clk = ~clk;

  raster_scanout #(.WIDTH(W), .HEIGHT(H), .HFP(HFP), .HSW(HSW), .HBP(HBP),
                   .VFP(VFP), .VSW(VSW), .VBP(VBP), .DEPTH(8), .CE_DIV(CE_A),
                   .AW(8), .BANK_OFS(OFS)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable_a), .bank(bank_a),
    .rd_addr(addr_a), .rd_data(ram_a), .ce_pix(ce_a), .video_out(vid_a),
    .hblank(hb_a), .vblank(vb_a), .hsync(hs_a), .vsync(vs_a),
    .frame_start(fs_a));

  raster_scanout #(.WIDTH(W), .HEIGHT(H), .HFP(HFP), .HSW(HSW), .HBP(HBP),
                   .VFP(VFP), .VSW(VSW), .VBP(VBP), .DEPTH(8), .CE_DIV(CE_B),
                   .AW(8), .BANK_OFS(OFS)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_b), .bank(1'b0),
    .rd_addr(addr_b), .rd_data(ram_b), .ce_pix(ce_b), .video_out(vid_b),
    .hblank(hb_b), .vblank(vb_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b));

  // Synchronous RAM models: data is the low byte of the address, one clk late.
  always @(posedge clk) begin
    ram_a <= addr_a;
    ram_b <= addr_b;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit vs_row(input int v);
    return (v >= H + VFP) && (v < H + VFP + VSW);
  endfunction

  function automatic void push_frame(input bit to_b, input int base,
                                     input bit first_run);
    for (int v = 0; v < VTOT; v++) begin
      for (int h = 0; h < HTOT; h++) begin
        exp_t e;
        bit   act;
        act     = (h < W) && (v < H);
        e.vid   = act ? 8'((base + v * W + h) % 256) : 8'h00;
        e.hb    = (h >= W);
        e.vb    = (v >= H);
        e.hs    = (h >= W + HFP) && (h < W + HFP + HSW);
        e.vs    = (h >= W + HFP) ? vs_row(v) : ((v > 0) ? vs_row(v - 1) : 1'b0);
        e.fs    = (h == 0) && (v == 0);
        e.first = first_run && e.fs;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
  endfunction

  // Scoreboard pop for the divide-by-4 instance.
  always @(negedge clk) begin
    exp_t e;
    gap_a++;
    if (ce_a) begin
      if (qa.size() == 0) check("spurious_ce_a", 32'(ce_a), 32'd0);
      else begin
        e = qa.pop_front();
        check("video_a", 32'(vid_a), 32'(e.vid));
        check("flags_a", 32'({hb_a, vb_a, hs_a, vs_a, fs_a}),
              32'({e.hb, e.vb, e.hs, e.vs, e.fs}));
        if (!e.first) check("ce_period_a", gap_a, CE_A);
      end
      gap_a = 0;
    end
  end

  // Scoreboard pop for the divide-by-2 instance.
  always @(negedge clk) begin
    exp_t e;
    gap_b++;
    if (ce_b) begin
      if (qb.size() == 0) check("spurious_ce_b", 32'(ce_b), 32'd0);
      else begin
        e = qb.pop_front();
        check("video_b", 32'(vid_b), 32'(e.vid));
        check("flags_b", 32'({hb_b, vb_b, hs_b, vs_b, fs_b}),
              32'({e.hb, e.vb, e.hs, e.vs, e.fs}));
        if (!e.first) check("ce_period_b", gap_b, CE_B);
      end
      gap_b = 0;
    end
  end

  task automatic wait_fs(input bit b, input int limit);
    int n    = 0;
    bit seen = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = b ? fs_b : fs_a;
    end
    check(b ? "frame_start_wait_b" : "frame_start_wait_a", 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_addr"}, 32'(addr_a), 32'd0);
    check({tag, "_video"},   32'(vid_a),  32'd0);
    check({tag, "_syncs"},   32'({ce_a, hs_a, vs_a, fs_a}), 32'd0);
    check({tag, "_blanks"},  32'({hb_a, vb_a}), 32'b11);
  endtask

  initial begin
    reset_n  = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b0;
    bank_a   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Three back-to-back frames: bank 0, bank 1 (wraps mod 256), bank 0.
    push_frame(1'b0, 0, 1'b1);
    push_frame(1'b0, OFS, 1'b0);
    push_frame(1'b0, 0, 1'b0);
    reset_n = 1'b1;
    wait_fs(1'b0, 1000);
    repeat (20) @(negedge clk);
    bank_a = 1'b1;
    wait_fs(1'b0, 1000);
    repeat (20) @(negedge clk);
    bank_a = 1'b0;
    wait_fs(1'b0, 1000);

    // Drop enable early in the third frame; it must still complete.
    repeat (40) @(negedge clk);
    enable_a = 1'b0;
    repeat (800) @(negedge clk);
    check("drain_after_disable", 32'(qa.size()), 32'd0);
    check("idle_blank", 32'({hb_a, vb_a}), 32'b11);

    // Re-enable, then pull reset asynchronously in the active region.
    push_frame(1'b0, 0, 1'b1);
    enable_a = 1'b1;
    wait_fs(1'b0, 1000);
    repeat (100) @(negedge clk);
    check("pre_reset_active", 32'({hb_a, vb_a}), 32'b00);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    qa.delete();
    @(negedge clk);
    push_frame(1'b0, 0, 1'b1);
    reset_n = 1'b1;
    wait_fs(1'b0, 1000);
    enable_a = 1'b0;
    repeat (800) @(negedge clk);
    check("drain_after_reset", 32'(qa.size()), 32'd0);

    // One frame on the divide-by-2 instance.
    push_frame(1'b1, 0, 1'b1);
    enable_b = 1'b1;
    wait_fs(1'b1, 1000);
    enable_b = 1'b0;
    repeat (400) @(negedge clk);
    check("drain_b", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
